// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : shared fixed-point types and helpers for the CNN datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int FXP_N = 16;
  localparam int FXP_Q = 12;

  typedef logic signed [FXP_N-1:0] fxp_t;

  localparam fxp_t FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};

  // Add in N+1 bits; the two top bits disagree exactly when the result overflowed.
  function automatic fxp_t sat_add(input fxp_t a, input fxp_t b);
    logic signed [FXP_N:0] s;
    s = {a[FXP_N-1], a} + {b[FXP_N-1], b};
    if (s[FXP_N] != s[FXP_N-1]) begin
      sat_add = s[FXP_N] ? FXP_MIN : FXP_MAX;
    end else begin
      sat_add = s[FXP_N-1:0];
    end
  endfunction

  function automatic fxp_t fxp_max(input fxp_t a, input fxp_t b);
    fxp_max = (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bias_relu.sv
// ============================================================================
// bias_relu : combinational saturating bias add followed by ReLU
// Rev 1.0
// ============================================================================
`default_nettype none

module bias_relu
  import cnn_pkg::*;
(
  input  fxp_t data_i,
  input  fxp_t bias_i,
  output fxp_t relu_o
);

  fxp_t w_sum;

  assign w_sum  = sat_add(data_i, bias_i);
  assign relu_o = w_sum[FXP_N-1] ? '0 : w_sum;

endmodule

`default_nettype wire

// File: rtl/relu_maxpool.sv
// ============================================================================
// relu_maxpool : per-map bias + ReLU followed by 2x2 stride-2 max-pooling
// Rev 1.0
// ============================================================================
`default_nettype none

module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int M = 3,
  parameter int N = FXP_N
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic signed [N-1:0] data_i,
  input  logic                val_i,
  input  logic                done_i,
  input  logic signed [N-1:0] bias_i,
  output logic        [N-1:0] pool_o,
  output logic                val_pool_o,
  output logic                done_pool_o
);

  localparam int HW  = M / 2;
  localparam int CW  = (M > 1) ? $clog2(M) : 1;
  localparam int HIW = (HW > 1) ? $clog2(HW) : 1;
  localparam int ODD = M % 2;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  fxp_t          tmp_q, tmp_d;
  fxp_t          pool_q, pool_d;
  logic          val_pool_q, val_pool_d;
  logic          done_pool_q;
  fxp_t          lb_q [HW];

  fxp_t          w_r;
  fxp_t          w_lb_rd;
  fxp_t          w_lb_wdata;
  logic [HIW-1:0] w_h;
  logic          w_col_last, w_row_last;
  logic          w_edge, w_beat;
  logic          w_row_odd, w_col_odd;
  logic          w_lb_we, w_emit;

  bias_relu u_bias_relu (
    .data_i (data_i),
    .bias_i (bias_i),
    .relu_o (w_r)
  );

  assign w_col_last = (col_q == CW'(M - 1));
  assign w_row_last = (row_q == CW'(M - 1));
  // With odd M the last column and last row fall outside every full window.
  assign w_edge     = (ODD != 0) && (w_col_last || w_row_last);
  assign w_beat     = val_i && !w_edge;
  assign w_row_odd  = row_q[0];
  assign w_col_odd  = col_q[0];
  assign w_h        = HIW'(col_q >> 1);

  always_comb begin
    w_lb_rd = '0;
    for (int i = 0; i < HW; i++) begin
      if (w_h == HIW'(i)) begin
        w_lb_rd = lb_q[i];
      end
    end
  end

  assign w_lb_we    = w_beat && !w_row_odd && w_col_odd;
  assign w_lb_wdata = fxp_max(tmp_q, w_r);
  assign w_emit     = w_beat && w_row_odd && w_col_odd;

  always_comb begin
    tmp_d = tmp_q;
    if (w_beat && !w_col_odd) begin
      tmp_d = w_row_odd ? fxp_max(w_lb_rd, w_r) : w_r;
    end
    if (done_i) begin
      tmp_d = '0;
    end
  end

  always_comb begin
    pool_d     = w_emit ? fxp_max(tmp_q, w_r) : pool_q;
    val_pool_d = w_emit;
  end

  // The beat is counted first; done_i then overrides so the next map starts at (0,0).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (val_i) begin
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (done_i) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      tmp_q       <= '0;
      pool_q      <= '0;
      val_pool_q  <= 1'b0;
      done_pool_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      tmp_q       <= tmp_d;
      pool_q      <= pool_d;
      val_pool_q  <= val_pool_d;
      done_pool_q <= done_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HW; i++) begin
        lb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HW; i++) begin
        if (w_lb_we && (w_h == HIW'(i))) begin
          lb_q[i] <= w_lb_wdata;
        end
      end
    end
  end

  assign pool_o      = pool_q;
  assign val_pool_o  = val_pool_q;
  assign done_pool_o = done_pool_q;

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool.sv
// ============================================================================
// tb_relu_maxpool : scoreboard bench for relu_maxpool (M=4 and M=3 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_relu_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] data;
  logic signed [15:0] bias;
  logic               val4, done4, val3, done3;
  logic [15:0]        pool4, pool3;
  logic               vp4, dp4, vp3, dp3;

  relu_maxpool #(.M(4), .N(16)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .val_i(val4), .done_i(done4),
    .bias_i(bias), .pool_o(pool4), .val_pool_o(vp4), .done_pool_o(dp4)
  );

  relu_maxpool #(.M(3), .N(16)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .val_i(val3), .done_i(done3),
    .bias_i(bias), .pool_o(pool3), .val_pool_o(vp3), .done_pool_o(dp3)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   dq4[$];
  int   dq3[$];

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  logic signed [15:0] dat[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", tag, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int relu_ref(input logic signed [15:0] d, input logic signed [15:0] b);
    int s;
    s = int'(d) + int'(b);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return (s < 0) ? 0 : s;
  endfunction

  task automatic idle();
    val4 = 1'b0; done4 = 1'b0; val3 = 1'b0; done3 = 1'b0;
  endtask

  // Drives dat[0..len-1] into the selected instance; expectations are the max of
  // each complete 2x2 window, due one cycle after the beat that closes it.
  task automatic send_map(input int m, input int len, input bit gaps, input bit with_done);
    for (int i = 0; i < len; i++) begin
      int row, col, mx, g;
      bit d;
      if (gaps) begin
        g = $urandom_range(3, 0);
        repeat (g) begin
          @(negedge clk);
          idle();
        end
      end
      @(negedge clk);
      idle();
      d    = with_done && (i == len - 1);
      data = dat[i];
      if (m == 4) begin val4 = 1'b1; done4 = d; end
      else        begin val3 = 1'b1; done3 = d; end
      row = i / m;
      col = i % m;
      if ((row % 2 == 1) && (col % 2 == 1) && (row < 2 * (m / 2)) && (col < 2 * (m / 2))) begin
        mx = relu_ref(dat[(row-1)*m + col-1], bias);
        if (relu_ref(dat[(row-1)*m + col], bias) > mx) mx = relu_ref(dat[(row-1)*m + col], bias);
        if (relu_ref(dat[row*m + col-1], bias) > mx)   mx = relu_ref(dat[row*m + col-1], bias);
        if (relu_ref(dat[row*m + col], bias) > mx)     mx = relu_ref(dat[row*m + col], bias);
        if (m == 4) q4.push_back('{mx, cyc + 1});
        else        q3.push_back('{mx, cyc + 1});
      end
      if (d) begin
        if (m == 4) dq4.push_back(cyc + 1);
        else        dq3.push_back(cyc + 1);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_q4_left"}, q4.size(), 0);
    check({tag, "_dq4_left"}, dq4.size(), 0);
    check({tag, "_q3_left"}, q3.size(), 0);
    check({tag, "_dq3_left"}, dq3.size(), 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   dc;
    #1;
    if (rst_n) begin
      if (vp4) begin
        if (q4.size() == 0) check("dut4_spurious_val", 1, 0);
        else begin
          e = q4.pop_front();
          check("dut4_pool", int'(pool4), e.val);
          check("dut4_latency", cyc, e.cyc);
        end
      end
      if (dp4) begin
        if (dq4.size() == 0) check("dut4_spurious_done", 1, 0);
        else begin dc = dq4.pop_front(); check("dut4_done_cycle", cyc, dc); end
      end
      if (vp3) begin
        if (q3.size() == 0) check("dut3_spurious_val", 1, 0);
        else begin
          e = q3.pop_front();
          check("dut3_pool", int'(pool3), e.val);
          check("dut3_latency", cyc, e.cyc);
        end
      end
      if (dp3) begin
        if (dq3.size() == 0) check("dut3_spurious_done", 1, 0);
        else begin dc = dq3.pop_front(); check("dut3_done_cycle", cyc, dc); end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    data  = '0;
    bias  = '0;
    idle();
    repeat (3) @(negedge clk);
    check("reset_pool4", int'(pool4), 0);
    check("reset_val4", int'(vp4), 0);
    check("reset_done4", int'(dp4), 0);
    check("reset_pool3", int'(pool3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending ramp, M=4
    for (int i = 0; i < 16; i++) dat[i] = 16'(i);
    bias = '0;
    send_map(4, 16, 1'b0, 1'b1);
    drain("ramp4");

    // Early end of map: only the first window completes
    send_map(4, 6, 1'b0, 1'b1);
    drain("early_done");

    // Odd map width: single window, edge beats consumed silently
    send_map(3, 9, 1'b0, 1'b1);
    drain("ramp3");

    // All-negative after bias, ReLU clamps to zero
    for (int i = 0; i < 16; i++) dat[i] = -16'sd4096;
    bias = 16'sh0800;
    send_map(4, 16, 1'b0, 1'b1);
    drain("relu_neg");

    // Positive and negative saturation
    for (int i = 0; i < 16; i++) dat[i] = 16'sh7000;
    bias = 16'sh7000;
    send_map(4, 16, 1'b0, 1'b1);
    drain("sat_hi");
    for (int i = 0; i < 16; i++) dat[i] = 16'sh8000;
    bias = 16'sh8000;
    send_map(4, 16, 1'b0, 1'b1);
    drain("sat_lo");

    // Ramp again with random bubbles between beats
    for (int i = 0; i < 16; i++) dat[i] = 16'(i);
    bias = '0;
    send_map(4, 16, 1'b1, 1'b1);
    drain("gaps");

    // Reset in the middle of a map, then a full clean map
    send_map(4, 10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_reset_pool4", int'(pool4), 7);
    rst_n = 1'b0;
    #1;
    check("midreset_pool4", int'(pool4), 0);
    check("midreset_val4", int'(vp4), 0);
    check("midreset_done4", int'(dp4), 0);
    check("midreset_q4", q4.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_map(4, 16, 1'b0, 1'b1);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
